// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier family.
// Recode-op and FSM state encodings are common to the sequential and array variants.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP,
        BOOTH_ADD,
        BOOTH_SUB
    } booth_op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: maps the bit pair {q_i, q_prev} to a skip/add/subtract step.
module booth_recode
    import booth_pkg::*;
(
    input  logic      q_i,
    input  logic      q_prev,
    output booth_op_e op
);

    logic valid;
    logic sign;

    assign valid = q_i ^ q_prev;
    assign sign  = q_i;

    always_comb begin
        op = BOOTH_NOP;
        if (valid) begin
            op = sign ? BOOTH_SUB : BOOTH_ADD;
        end
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one recode step per clock on a shared accumulator,
// operands in and product out through valid/ready handshakes.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_1,
    input  logic [WIDTH-1:0]   op_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = clog2(WIDTH) + (((WIDTH & (WIDTH - 1)) == 0) ? 1 : 0);

    state_e           state_q, state_d;
    logic [PW-1:0]    m_q, m_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_prev_q, q_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    booth_op_e     step_op;
    logic [PW-1:0] addend;
    logic          carry_in;
    logic [PW-1:0] sum;

    // m_q shifts left and q_q shifts right each step, so m_q == M << cnt and q_q[0] == Q[cnt].
    booth_recode u_recode (
        .q_i    (q_q[0]),
        .q_prev (q_prev_q),
        .op     (step_op)
    );

    always_comb begin
        addend   = '0;
        carry_in = 1'b0;
        unique case (step_op)
            BOOTH_ADD: addend = m_q;
            BOOTH_SUB: begin
                addend   = ~m_q;
                carry_in = 1'b1;
            end
            default: ;
        endcase
        sum = acc_q + addend + PW'(carry_in);
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        q_prev_d = q_prev_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d      = {{WIDTH{op_1[WIDTH-1]}}, op_1};
                    q_d      = op_2;
                    q_prev_d = 1'b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum;
                q_prev_d = q_q[0];
                q_d      = q_q >> 1;
                m_d      = m_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            q_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            q_prev_q <= q_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = acc_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and randomised checks of booth_seq_ctrl at WIDTH=8.
module tb_booth_seq_ctrl;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   op_1 = '0;
    logic [W-1:0]   op_2 = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    booth_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_1      (op_1),
        .op_2      (op_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // lat counts clock edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          output logic [15:0] res, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        op_1     = a;
        op_2     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'(result), 32'(res));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] res;
    int          lat;

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(8'd3, 8'd5, 0, res, lat);
        check("3x5", 32'(res), 32'h000F);
        check("3x5_lat", 32'(lat), 32'(W));
        check("3x5_ready_after", 32'(in_ready), 32'd1);

        run_op(8'hFD, 8'd5, 1, res, lat);
        check("m3x5", 32'(res), 32'hFFF1);
        run_op(8'h80, 8'h80, 0, res, lat);
        check("m128xm128", 32'(res), 32'h4000);
        run_op(8'h80, 8'h7F, 2, res, lat);
        check("m128x127", 32'(res), 32'hC080);
        run_op(8'h5A, 8'h00, 0, res, lat);
        check("5Ax0", 32'(res), 32'h0000);
        check("5Ax0_lat", 32'(lat), 32'(W));

        // Long stall in DONE with a competing request that must be ignored.
        run_op(8'h5A, 8'hFF, 0, res, lat);
        check("5AxFF_pre", 32'(res), 32'hFFA6);
        check("5AxFF_lat", 32'(lat), 32'(W));
        run_op(8'h5A, 8'hFF, 0, res, lat);
        check("5AxFF_again", 32'(res), 32'hFFA6);
        op_1 = 8'h11;
        op_2 = 8'h22;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("stall_setup_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            op_1 = 8'h33;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'h0242);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pulse_in_ready", 32'(in_ready), 32'd1);
        check("pulse_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("no_ghost_op", 32'(busy), 32'd0);

        // Reset partway through RUN, after four steps.
        op_1 = 8'd3;
        op_2 = 8'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_acc", 32'(result), 32'h000F);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(8'd7, 8'hFE, 0, res, lat);
        check("7xm2", 32'(res), 32'hFFF2);
        check("7xm2_lat", 32'(lat), 32'(W));

        for (int t = 0; t < 1500; t++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_op(a, b, int'($urandom_range(0, 3)), res, lat);
            check("rand_result", 32'(res), 32'(ref_mul(a, b)));
            check("rand_lat", 32'(lat), 32'(W));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
